edge_gen: RTL and testbench

- Programmable edge/pulse-train generator: the transmit-side counterpart of the team's edge-detector/counter blocks.
- Accepts a command (pulse count, high width, low width) over a valid/ready handshake and drives a registered pulse train on `out`.
- Signals completion with a one-cycle `done` strobe.
- Used to stimulate and drive edge-counting logic with a known number of edges at known spacing.

---
 rtl/edge_gen_if.sv | 28 ++
 rtl/edge_gen.sv | 103 ++++++++++
 tb/tb_edge_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/edge_gen_if.sv
// Command channel for edge_gen: pulse count and phase lengths over valid/ready.
// The master drives the command; the slave (edge_gen) returns start_ready.
interface edge_gen_if #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [CNT_W-1:0] num_pulses;
  logic [PER_W-1:0] high_len;
  logic [PER_W-1:0] low_len;

  modport master (
    output start_valid,
    output num_pulses,
    output high_len,
    output low_len,
    input  start_ready
  );

  modport slave (
    input  start_valid,
    input  num_pulses,
    input  high_len,
    input  low_len,
    output start_ready
  );
endinterface

// File: rtl/edge_gen.sv
// Programmable pulse-train generator: emits num_pulses pulses of high_len/low_len
// cycles each, then a one-cycle done strobe. All outputs decode registered state.
module edge_gen #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             x,
  edge_gen_if.slave        cmd,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] num_r;
  logic [PER_W-1:0] high_r;
  logic [PER_W-1:0] low_r;
  logic [PER_W-1:0] phase_cnt;
  logic [PER_W-1:0] eff_h;
  logic [PER_W-1:0] eff_l;
  logic             accept;

  // Zero-length phases are stretched to one cycle so every pulse is visible.
  always_comb begin
    eff_h = (cmd.high_len == '0) ? PER_W'(1) : cmd.high_len;
    eff_l = (cmd.low_len  == '0) ? PER_W'(1) : cmd.low_len;
  end

  assign accept = cmd.start_valid && (state == IDLE);

  always_ff @(posedge clk or posedge x) begin
    if (x) begin
      state       <= IDLE;
      num_r       <= '0;
      high_r      <= '0;
      low_r       <= '0;
      phase_cnt   <= '0;
      pulses_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            num_r  <= cmd.num_pulses;
            high_r <= eff_h;
            low_r  <= eff_l;
            if (cmd.num_pulses == '0) begin
              state       <= DONE;
              pulses_sent <= '0;
            end else begin
              state       <= HIGH;
              phase_cnt   <= eff_h - PER_W'(1);
              pulses_sent <= CNT_W'(1);
            end
          end
        end
        HIGH: begin
          if (abort) begin
            state <= DONE;
          end else if (phase_cnt == '0) begin
            state     <= LOW;
            phase_cnt <= low_r - PER_W'(1);
          end else begin
            phase_cnt <= phase_cnt - PER_W'(1);
          end
        end
        LOW: begin
          if (abort) begin
            state <= DONE;
          end else if (phase_cnt == '0) begin
            // The last pulse still gets its full low phase before DONE.
            if (pulses_sent < num_r) begin
              state     <= HIGH;
              phase_cnt <= high_r - PER_W'(1);
              if (pulses_sent != '1)
                pulses_sent <= pulses_sent + CNT_W'(1);
            end else begin
              state <= DONE;
            end
          end else begin
            phase_cnt <= phase_cnt - PER_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cmd.start_ready = (state == IDLE);
  assign out             = (state == HIGH);
  assign busy            = (state == HIGH) || (state == LOW);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_edge_gen.sv
// Scoreboard bench for edge_gen: each issued command pushes its expected waveform,
// latency and pulse count; a negedge monitor pops and compares on every done strobe.
module tb_edge_gen;

  logic       clk;
  logic       x;
  logic       abort;
  logic       out;
  logic       busy;
  logic       done;
  logic [7:0] pulses_sent;

  edge_gen_if #(.CNT_W(8), .PER_W(8)) cmd_if ();

  edge_gen #(.CNT_W(8), .PER_W(8)) dut (
    .clk         (clk),
    .x           (x),
    .cmd         (cmd_if),
    .abort       (abort),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    lat;
    int    ps;
    string wave;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   tb_cyc = 0;

  always @(posedge clk) tb_cyc++;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic chk_s(input string name, input string act, input string expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, expv);
  endtask

  // Monitor: tracks each accepted command from T+1 until its done strobe.
  bit    pend = 0, active = 0, after_done = 0, busy_bad = 0;
  int    mcyc;
  string wave;

  always @(negedge clk) begin
    if (x) begin
      pend = 0; active = 0; after_done = 0;
    end else begin
      if (after_done) begin
        chk("ready_after_done", int'(cmd_if.start_ready), 1);
        after_done = 0;
      end
      if (pend) begin
        active = 1; mcyc = 0; wave = ""; busy_bad = 0; pend = 0;
      end
      if (active) begin
        mcyc++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("done_without_expectation", int'(done), 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_latency", mcyc, e.lat);
            chk("pulses_sent", int'(pulses_sent), e.ps);
            chk_s("out_wave", wave, e.wave);
            chk("busy_in_done", int'(busy), 0);
            chk("ready_in_done", int'(cmd_if.start_ready), 0);
            chk("busy_during_train", int'(busy_bad), 0);
          end
          active = 0;
          after_done = 1;
        end else begin
          wave = {wave, (out ? "1" : "0")};
          if (!busy) busy_bad = 1;
        end
      end else if (done) begin
        chk("spurious_done", int'(done), 0);
      end
      if (cmd_if.start_valid && cmd_if.start_ready) pend = 1;
    end
  end

  task automatic push_exp(input int lat, input int ps, input string w);
    exp_t e;
    e.lat = lat; e.ps = ps; e.wave = w;
    sb.push_back(e);
  endtask

  // Returns #1 into cycle T+1, where T is the accept cycle.
  task automatic send(input int n, input int h, input int l);
    bit ok;
    ok = 0;
    cmd_if.start_valid = 1'b1;
    cmd_if.num_pulses  = 8'(n);
    cmd_if.high_len    = 8'(h);
    cmd_if.low_len     = 8'(l);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_if.start_ready) ok = 1;
    end
    @(posedge clk); #1;
    cmd_if.start_valid = 1'b0;
    abort = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int c[2];
    x = 1'b1;
    abort = 1'b0;
    cmd_if.start_valid = 1'b0;
    cmd_if.num_pulses  = '0;
    cmd_if.high_len    = '0;
    cmd_if.low_len     = '0;
    #12;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulses", int'(pulses_sent), 0);
    chk("rst_ready", int'(cmd_if.start_ready), 1);
    @(negedge clk); x = 1'b0;
    @(posedge clk); #1;

    push_exp(11, 2, "1110011100");
    send(2, 3, 2); wait_done();

    push_exp(1, 0, "");
    send(0, 5, 5); wait_done();

    push_exp(7, 3, "101010");
    send(3, 0, 0); wait_done();

    // Abort in the second cycle of the third pulse's high phase.
    push_exp(19, 3, "111100001111000011");
    send(5, 4, 4);
    repeat (17) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done();

    // Abort alongside start in IDLE must be ignored.
    push_exp(4, 1, "110");
    abort = 1'b1;
    send(1, 2, 1); wait_done();

    // Start while busy is ignored; then async reset mid-train.
    send(3, 2, 2);
    @(posedge clk); #1;
    cmd_if.start_valid = 1'b1;
    cmd_if.num_pulses  = 8'd1;
    cmd_if.high_len    = 8'd1;
    cmd_if.low_len     = 8'd7;
    @(posedge clk); #1 cmd_if.start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midtrain_out", int'(out), 1);
    chk("midtrain_pulses", int'(pulses_sent), 2);
    chk("midtrain_busy", int'(busy), 1);
    #2 x = 1'b1;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_pulses", int'(pulses_sent), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk); #1 x = 1'b0;
    @(posedge clk); #1;

    // Back-to-back with start_valid held high.
    push_exp(3, 1, "10");
    push_exp(3, 1, "10");
    cmd_if.start_valid = 1'b1;
    cmd_if.num_pulses  = 8'd1;
    cmd_if.high_len    = 8'd1;
    cmd_if.low_len     = 8'd1;
    acc = 0;
    c[0] = 0; c[1] = 0;
    for (int i = 0; i < 50 && acc < 2; i++) begin
      @(negedge clk);
      if (cmd_if.start_ready) begin
        c[acc] = tb_cyc;
        acc++;
      end
    end
    @(posedge clk); #1 cmd_if.start_valid = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_gap", c[1] - c[0], 4);
    wait_done();
    repeat (3) @(posedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
